// File: rtl/i2c_pkg.sv
// I2C target shared types: FSM state encoding and bus-level constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // True when the 7 address bits of a received address byte equal addr.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] addr);
        return addr_byte[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_target_responder_if.sv
// Pin and register-port bundle of the I2C target responder.
// Latency: n/a (wires only).
// Backpressure: none; the register port is a fire-and-forget pulse plus a read mux.
interface i2c_target_responder_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, rd_data,
        output sda_oe, wr_valid, wr_addr, wr_data, rd_addr, busy
    );

    modport master (
        output scl_i, sda_i, rd_data,
        input  sda_oe, wr_valid, wr_addr, wr_data, rd_addr, busy
    );
endinterface

// File: rtl/i2c_sync_edge.sv
// Synchronizes SCL/SDA and flags SCL edges plus START/STOP conditions.
// Latency: SYNC_STAGES clk to the synchronized level, edge flags valid in that same clk.
// Backpressure: none; flags are single-clk pulses.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Synchronizer chains plus one history bit; reset to the idle-high bus level
    // so leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    // SDA moving while SCL is stably high is a bus condition, never data.
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: address match/ACK, pointer-addressed register writes and reads.
// Latency: sda_oe follows a pin SCL fall by SYNC_STAGES+1 clk; wr_valid rises with the data ACK.
// Backpressure: none; no clock stretching, wr_valid is a 1-clk pulse with no ready.
module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h20,
    parameter int         SYNC_STAGES = 2
) (
    input logic                    clk,
    input logic                    rst,
    i2c_target_responder_if.slave  bus
);

    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;

    i2c_state_e state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] ptr_q;
    logic       rw_q;
    logic       first_q;
    logic       sda_oe_q;
    logic       wr_valid_q;
    logic [7:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic       busy_q;
    logic [7:0] shift_in;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (bus.scl_i),
        .sda_i      (bus.sda_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    assign shift_in = {shift_q[6:0], sda_s};

    // Protocol FSM: START/STOP override everything, data sampled on SCL rise,
    // SDA only ever changed on SCL fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            ptr_q      <= 8'h00;
            rw_q       <= RW_WRITE;
            first_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            wr_valid_q <= 1'b0;
            if (start_det) begin
                state_q   <= ST_ADDR;
                bit_cnt_q <= 3'd0;
                sda_oe_q  <= 1'b0;
            end else if (stop_det) begin
                state_q  <= ST_IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= shift_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (addr_match(shift_in, TARGET_ADDR)) begin
                                    state_q <= ST_ADDR_ACK;
                                    busy_q  <= 1'b1;
                                    rw_q    <= shift_in[0];
                                end else begin
                                    state_q <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        // First fall drives the ACK, second fall ends the ACK slot.
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                            end else if (rw_q == RW_READ) begin
                                shift_q   <= bus.rd_data;
                                sda_oe_q  <= ~bus.rd_data[7];
                                ptr_q     <= ptr_q + 8'd1;
                                bit_cnt_q <= 3'd0;
                                state_q   <= ST_RD_BYTE;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 3'd0;
                                first_q   <= 1'b1;
                                state_q   <= ST_WR_BYTE;
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (scl_rise) begin
                            shift_q   <= shift_in;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        // The byte is committed only once it is acknowledged, so a
                        // STOP inside the byte never produces a write.
                        if (scl_fall) begin
                            if (!sda_oe_q) begin
                                sda_oe_q <= 1'b1;
                                if (first_q) begin
                                    ptr_q   <= shift_q;
                                    first_q <= 1'b0;
                                end else begin
                                    wr_valid_q <= 1'b1;
                                    wr_addr_q  <= ptr_q;
                                    wr_data_q  <= shift_q;
                                    ptr_q      <= ptr_q + 8'd1;
                                end
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 3'd0;
                                state_q   <= ST_WR_BYTE;
                            end
                        end
                    end
                    ST_RD_BYTE: begin
                        // Bit 7 went out at load; each fall presents the next bit.
                        if (scl_fall) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= ST_RD_ACK;
                            end else begin
                                shift_q  <= {shift_q[6:0], 1'b0};
                                sda_oe_q <= ~shift_q[6];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise && sda_s == I2C_NACK) begin
                            state_q <= ST_IGNORE;
                        end else if (scl_fall) begin
                            shift_q   <= bus.rd_data;
                            sda_oe_q  <= ~bus.rd_data[7];
                            ptr_q     <= ptr_q + 8'd1;
                            bit_cnt_q <= 3'd0;
                            state_q   <= ST_RD_BYTE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rd_addr  = ptr_q;
    assign bus.busy     = busy_q;

endmodule
